// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multicycle MIPS controller and its shared datapath.
//
// Handshake: mem_req is the controller's "valid" for a memory access and is
// held, together with iord/mem_write, until the cycle in which mem_ready is
// high; that cycle completes the access. mem_ready while mem_req=0 is ignored.
//
// master : controller side (decodes op/funct/zero, drives the selects/enables)
// slave  : datapath side
//
// Signals
//   op[5:0], funct[5:0]  IR fields          zero       ALU zero flag
//   mem_ready            memory done        pc_en      PC load enable
//   iord                 mem addr select    mem_req    memory access active
//   mem_write            store strobe       ir_write   IR load enable
//   reg_dst              rt/rd select       mem_to_reg ALUOut/Data select
//   reg_write            regfile write      alu_src_a  PC/A select
//   alu_src_b[1:0]       B/4/imm/imm<<2     imm_src    sign/zero/lui extend
//   alu_control[2:0]     ALU operation      pc_src     ALU/ALUOut/jump
//   illegal              unsupported opcode pulse
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic [1:0] pc_src;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_en, iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, imm_src, alu_control, pc_src,
           illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_en, iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, imm_src, alu_control, pc_src,
           illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore control FSM for a multicycle MIPS datapath (PC, unified memory, IR,
// regfile, ALU, extenders). One datapath step per clock; memory accesses
// stall on the mem_req/mem_ready handshake.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   bus       multicycle_ctrl_if.master (IR fields in, control out)
//   state_o   current state (debug), reads FETCH while reset is high
//   cycle_cnt, instr_cnt   perf counters, only with MC_CTRL_PERF_EN
//
// Optional feature macro: MC_CTRL_PERF_EN (cycle / retired-instruction
// counters). Undefined by default; nothing else changes.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int STATE_W = 4
`ifdef MC_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus,
  output logic [STATE_W-1:0] state_o
`ifdef MC_CTRL_PERF_EN
  , output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_RTYPEEX = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_RTYPEWB = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BEQEX   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_ADDIEX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_LOGIEX  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_IWB     = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_JEX     = STATE_W'(12);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [STATE_W-1:0] state_q, state_d;
  // State the outputs decode from: reset presents FETCH immediately, even
  // though the register itself only returns to FETCH on the next edge.
  logic [STATE_W-1:0] cur_state;

  logic       pc_write, branch;
  logic       pc_en_c, iord_c, mem_req_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c, illegal_c;
  logic [1:0] alu_src_b_c, imm_src_c, pc_src_c;
  logic [2:0] alu_control_c;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_RTYPE:                state_d = S_RTYPEEX;
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_BEQ:                  state_d = S_BEQEX;
          OP_ADDI:                 state_d = S_ADDIEX;
          OP_ANDI, OP_ORI, OP_LUI: state_d = S_LOGIEX;
          OP_J:                    state_d = S_JEX;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_IWB;
      S_LOGIEX:  state_d = S_IWB;
      S_IWB:     state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  assign cur_state = reset ? S_FETCH : state_q;

  always_comb begin
    pc_write      = 1'b0;
    branch        = 1'b0;
    iord_c        = 1'b0;
    mem_req_c     = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    reg_dst_c     = 1'b0;
    mem_to_reg_c  = 1'b0;
    reg_write_c   = 1'b0;
    alu_src_a_c   = 1'b0;
    alu_src_b_c   = 2'b00;
    imm_src_c     = 2'b00;
    alu_control_c = ALU_AND;
    pc_src_c      = 2'b00;
    illegal_c     = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_req_c     = 1'b1;
        alu_src_b_c   = 2'b01;
        alu_control_c = ALU_ADD;
        // IR and PC only load in the cycle the fetch actually completes.
        ir_write_c    = bus.mem_ready;
        pc_write      = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_b_c   = 2'b11;
        alu_control_c = ALU_ADD;
        case (bus.op)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
          OP_ANDI, OP_ORI, OP_LUI, OP_J: illegal_c = 1'b0;
          default:                       illegal_c = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = 2'b10;
        alu_control_c = ALU_ADD;
      end
      S_MEMRD: begin
        iord_c    = 1'b1;
        mem_req_c = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
      end
      S_MEMWR: begin
        iord_c      = 1'b1;
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a_c = 1'b1;
        case (bus.funct)
          6'b100000: alu_control_c = ALU_ADD;
          6'b100010: alu_control_c = ALU_SUB;
          6'b100100: alu_control_c = ALU_AND;
          6'b100101: alu_control_c = ALU_OR;
          6'b101010: alu_control_c = ALU_SLT;
          default:   alu_control_c = ALU_ADD;
        endcase
      end
      S_RTYPEWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a_c   = 1'b1;
        alu_control_c = ALU_SUB;
        branch        = 1'b1;
        pc_src_c      = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = 2'b10;
        alu_control_c = ALU_ADD;
      end
      S_LOGIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        // lui is "or" with A=$0 (rs field is 0), so the shifted immediate
        // passes through unchanged.
        case (bus.op)
          OP_ANDI: begin imm_src_c = 2'b01; alu_control_c = ALU_AND; end
          OP_ORI:  begin imm_src_c = 2'b01; alu_control_c = ALU_OR;  end
          default: begin imm_src_c = 2'b10; alu_control_c = ALU_OR;  end
        endcase
      end
      S_IWB: begin
        reg_write_c = 1'b1;
      end
      S_JEX: begin
        pc_write = 1'b1;
        pc_src_c = 2'b10;
      end
      default: ;
    endcase

    pc_en_c = pc_write | (branch & bus.zero);

    // No enable or request may leave the controller while reset is high.
    if (reset) begin
      pc_en_c     = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      mem_write_c = 1'b0;
      mem_req_c   = 1'b0;
      illegal_c   = 1'b0;
    end
  end

  assign bus.pc_en       = pc_en_c;
  assign bus.iord        = iord_c;
  assign bus.mem_req     = mem_req_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.ir_write    = ir_write_c;
  assign bus.reg_dst     = reg_dst_c;
  assign bus.mem_to_reg  = mem_to_reg_c;
  assign bus.reg_write   = reg_write_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.imm_src     = imm_src_c;
  assign bus.alu_control = alu_control_c;
  assign bus.pc_src      = pc_src_c;
  assign bus.illegal     = illegal_c;
  assign state_o         = cur_state;

`ifdef MC_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Perf counters. An instruction retires on any entry into FETCH except from
  // DECODE, which only happens on the illegal-opcode path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (state_q != S_FETCH && state_q != S_DECODE && state_d == S_FETCH)
        instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Each instruction is described as an
// expected state trace plus the mem_ready value to present in each cycle;
// the per-cycle write enables and selects are derived from the state table.
// Inputs change at the falling edge, outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
  logic       clk;
  logic       reset;
  logic [3:0] state_o;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
  logic [31:0] c0, i0;
`endif

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];
  logic       rdy_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_rtype(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] o);
    case (o)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
      6'b001100, 6'b001101, 6'b001111, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Push n states packed as nibbles (first state in the top nibble used),
  // all with mem_ready=1.
  task automatic queue_seq(input logic [31:0] seq, input int n);
    logic [31:0] s;
    s = seq;
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back(s[i*4 +: 4]);
      rdy_q.push_back(1'b1);
    end
  endtask

  task automatic add(input logic [3:0] st, input logic rdy);
    exp_q.push_back(st);
    rdy_q.push_back(rdy);
  endtask

  // Drain the expected trace, one state per clock.
  task automatic run_q(input string tag);
    logic [3:0] st;
    logic       rdy;
    while (exp_q.size() > 0) begin
      st  = exp_q.pop_front();
      rdy = rdy_q.pop_front();
      @(negedge clk);
      bus.mem_ready = rdy;
      #1;
      check({tag, "_state"},     32'(state_o),       32'(st));
      check({tag, "_reg_write"}, 32'(bus.reg_write), 32'(st == 4 || st == 7 || st == 11));
      check({tag, "_mem_write"}, 32'(bus.mem_write), 32'(st == 5));
      check({tag, "_mem_req"},   32'(bus.mem_req),   32'(st == 0 || st == 3 || st == 5));
      check({tag, "_iord"},      32'(bus.iord),      32'(st == 3 || st == 5));
      check({tag, "_ir_write"},  32'(bus.ir_write),  32'(st == 0 && rdy));
      check({tag, "_pc_en"},     32'(bus.pc_en),
            32'((st == 0 && rdy) || st == 12 || (st == 8 && bus.zero)));
      check({tag, "_illegal"},   32'(bus.illegal),   32'(st == 1 && !op_legal(bus.op)));
      check({tag, "_mem_to_reg"}, 32'(bus.mem_to_reg), 32'(st == 4));
      check({tag, "_reg_dst"},   32'(bus.reg_dst),   32'(st == 7));
      case (st)
        4'd1: check({tag, "_srcb_dec"}, 32'(bus.alu_src_b), 32'd3);
        4'd6: check({tag, "_alu_r"}, 32'(bus.alu_control), 32'(exp_rtype(bus.funct)));
        4'd8: begin
          check({tag, "_alu_beq"}, 32'(bus.alu_control), 32'b110);
          check({tag, "_pcsrc_beq"}, 32'(bus.pc_src), 32'd1);
        end
        4'd9: begin
          check({tag, "_imm_addi"}, 32'(bus.imm_src), 32'd0);
          check({tag, "_srcb_addi"}, 32'(bus.alu_src_b), 32'd2);
        end
        4'd10: begin
          check({tag, "_imm_logi"}, 32'(bus.imm_src),
                (bus.op == 6'b001111) ? 32'd2 : 32'd1);
          check({tag, "_alu_logi"}, 32'(bus.alu_control),
                (bus.op == 6'b001100) ? 32'b000 : 32'b001);
        end
        4'd12: check({tag, "_pcsrc_j"}, 32'(bus.pc_src), 32'd2);
        default: ;
      endcase
    end
  endtask

  // Hold reset for n cycles; mem_ready is low throughout.
  task automatic do_reset(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      bus.mem_ready = 1'b0;
      #1;
      check({tag, "_state"},     32'(state_o),       32'd0);
      check({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
      check({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
      check({tag, "_reg_write"}, 32'(bus.reg_write), 32'd0);
      check({tag, "_ir_write"},  32'(bus.ir_write),  32'd0);
      check({tag, "_pc_en"},     32'(bus.pc_en),     32'd0);
      check({tag, "_iord"},      32'(bus.iord),      32'd0);
      check({tag, "_srcb"},      32'(bus.alu_src_b), 32'd1);
      check({tag, "_alu"},       32'(bus.alu_control), 32'b010);
`ifdef MC_CTRL_PERF_EN
      if (i > 0) begin
        check({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
        check({tag, "_instr_cnt"}, instr_cnt, 32'd0);
      end
`endif
    end
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.op        = 6'd0;
    bus.funct     = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    do_reset("rst", 2);

    // lw: 0,1,2,3,4
    bus.op = 6'b100011;
    queue_seq(32'h01234, 5);
    run_q("lw");

    // R-type: add, sub, slt, unknown funct (-> add)
    bus.op = 6'b000000;
    bus.funct = 6'b100000; queue_seq(32'h0167, 4); run_q("r_add");
    bus.funct = 6'b100010; queue_seq(32'h0167, 4); run_q("r_sub");
    bus.funct = 6'b101010; queue_seq(32'h0167, 4); run_q("r_slt");
    bus.funct = 6'b100101; queue_seq(32'h0167, 4); run_q("r_or");
    bus.funct = 6'b000011; queue_seq(32'h0167, 4); run_q("r_unk");

    // beq taken / not taken
    bus.op = 6'b000100;
    bus.zero = 1'b1; queue_seq(32'h018, 3); run_q("beq_t");
    bus.zero = 1'b0; queue_seq(32'h018, 3); run_q("beq_nt");

    // immediates
    bus.op = 6'b001000; queue_seq(32'h019B, 4); run_q("addi");
    bus.op = 6'b001100; queue_seq(32'h01AB, 4); run_q("andi");
    bus.op = 6'b001101; queue_seq(32'h01AB, 4); run_q("ori");
    bus.op = 6'b001111; queue_seq(32'h01AB, 4); run_q("lui");

    // jump
    bus.op = 6'b000010; queue_seq(32'h01C, 3); run_q("j");

    // sw with 3 stall cycles in MEMWR: 7 cycles total
    bus.op = 6'b101011;
    add(4'd0, 1'b1); add(4'd1, 1'b1); add(4'd2, 1'b1);
    add(4'd5, 1'b0); add(4'd5, 1'b0); add(4'd5, 1'b0); add(4'd5, 1'b1);
    run_q("sw_stall");

    // illegal opcode: FETCH, DECODE (pulse), back to FETCH (held by mem_ready=0)
    bus.op = 6'b111111;
    add(4'd0, 1'b1); run_q("ill");
`ifdef MC_CTRL_PERF_EN
    c0 = cycle_cnt;
    i0 = instr_cnt;
`endif
    add(4'd1, 1'b1); add(4'd0, 1'b0); run_q("ill");
`ifdef MC_CTRL_PERF_EN
    check("ill_cycle_cnt", cycle_cnt - c0, 32'd2);
    check("ill_instr_cnt", instr_cnt, i0);
`endif

    // sw interrupted by reset while stalled in MEMWR
    bus.op = 6'b101011;
    add(4'd0, 1'b1); add(4'd1, 1'b1); add(4'd2, 1'b1); add(4'd5, 1'b0);
    run_q("sw_pre");
    do_reset("rst_mid", 2);
    add(4'd0, 1'b0); add(4'd0, 1'b0); add(4'd0, 1'b1);
    add(4'd1, 1'b1); add(4'd2, 1'b1); add(4'd5, 1'b1);
    run_q("sw_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
